// File: rtl/imm_pkg.sv
// Shared types and RV opcode constants for the pipelined immediate generator.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6,
    FMT_SH   = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate/format decode of a 32-bit RV instruction, extended to XLEN.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o,
  output logic            err_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] raw;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];

  always_comb begin
    raw   = '0;
    fmt_o = FMT_NONE;
    err_o = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_JALR: begin
        fmt_o = FMT_I;
        raw   = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OPC_OPIMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          fmt_o = FMT_SH;
          if (XLEN == 64) begin
            raw = {26'd0, instr_i[25:20]};
          end else begin
            raw   = {27'd0, instr_i[24:20]};
            err_o = instr_i[25];
          end
        end else begin
          fmt_o = FMT_I;
          raw   = {{20{instr_i[31]}}, instr_i[31:20]};
        end
      end
      OPC_STORE: begin
        fmt_o = FMT_S;
        raw   = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      OPC_BRANCH: begin
        fmt_o = FMT_B;
        raw   = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                 instr_i[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_o = FMT_U;
        raw   = {instr_i[31:12], 12'd0};
      end
      OPC_JAL: begin
        fmt_o = FMT_J;
        raw   = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                 instr_i[30:21], 1'b0};
      end
      OPC_SYSTEM: begin
        if (funct3 == 3'b101 || funct3 == 3'b110 || funct3 == 3'b111) begin
          fmt_o = FMT_Z;
          raw   = {27'd0, instr_i[19:15]};
        end
      end
      default: begin
        raw   = '0;
        fmt_o = FMT_NONE;
      end
    endcase
  end

  // Zero-extended forms keep raw[31]=0, so one signed widening covers every format.
  assign imm_o = XLEN'($signed(raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate decoder: one-cycle latency behind a main + skid buffer pair.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [2:0]       fmt_out,
  output logic             imm_err,
  output logic [TAG_W-1:0] tag_out
);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_xlen_check
    $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_err;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr_i (in_instr),
    .imm_o   (dec_imm),
    .fmt_o   (dec_fmt),
    .err_o   (dec_err)
  );

  logic             main_valid_q, main_valid_d;
  logic [XLEN-1:0]  main_imm_q,   main_imm_d;
  fmt_e             main_fmt_q,   main_fmt_d;
  logic             main_err_q,   main_err_d;
  logic [TAG_W-1:0] main_tag_q,   main_tag_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  fmt_e             skid_fmt_q,   skid_fmt_d;
  logic             skid_err_q,   skid_err_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

  // Handshake: a beat moves on a rising edge where valid && ready; in_ready is a
  // flop (!skid_valid_q) so no combinational path runs from out_ready to in_ready.
  logic accept, consume;
  assign accept  = in_valid && !skid_valid_q;
  assign consume = main_valid_q && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_fmt_d   = main_fmt_q;
    main_err_d   = main_err_q;
    main_tag_d   = main_tag_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    skid_err_d   = skid_err_q;
    skid_tag_d   = skid_tag_q;
    if (consume && skid_valid_q) begin
      main_imm_d   = skid_imm_q;
      main_fmt_d   = skid_fmt_q;
      main_err_d   = skid_err_q;
      main_tag_d   = skid_tag_q;
      skid_valid_d = 1'b0;
    end else if (accept && (!main_valid_q || consume)) begin
      main_valid_d = 1'b1;
      main_imm_d   = dec_imm;
      main_fmt_d   = dec_fmt;
      main_err_d   = dec_err;
      main_tag_d   = in_tag;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_fmt_d   = dec_fmt;
      skid_err_d   = dec_err;
      skid_tag_d   = in_tag;
    end else if (consume) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_fmt_q   <= FMT_NONE;
      main_err_q   <= 1'b0;
      main_tag_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= FMT_NONE;
      skid_err_q   <= 1'b0;
      skid_tag_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_fmt_q   <= main_fmt_d;
      main_err_q   <= main_err_d;
      main_tag_q   <= main_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_err_q   <= skid_err_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign imm_out   = main_imm_q;
  assign fmt_out   = main_fmt_q;
  assign imm_err   = main_err_q;
  assign tag_out   = main_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one input stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        rdy32, rdy64, ov32, ov64, err32, err64;
  logic [31:0] imm32, tag32, tag64;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;
  logic [63:0] exp_q[$];
  logic        stall_q = 1'b0;
  logic [63:0] held_imm;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(ov32), .out_ready(out_ready),
    .imm_out(imm32), .fmt_out(fmt32), .imm_err(err32), .tag_out(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(ov64), .out_ready(out_ready),
    .imm_out(imm64), .fmt_out(fmt64), .imm_err(err64), .tag_out(tag64)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference decode, straight from the ISA immediate rules as signed integers.
  function automatic void ref_dec(input logic [31:0] w, input int xl,
                                  output logic [63:0] imm, output logic [2:0] fmt,
                                  output logic err);
    longint v;
    int op, f3;
    op = int'(w[6:0]);
    f3 = int'(w[14:12]);
    v = 0; fmt = 3'd0; err = 1'b0;
    case (op)
      'h03, 'h67: begin fmt = 3'd1; v = longint'($signed(w[31:20])); end
      'h13: begin
        if (f3 == 1 || f3 == 5) begin
          fmt = 3'd7;
          if (xl == 64) v = longint'(w[25:20]);
          else begin v = longint'(w[24:20]); err = w[25]; end
        end else begin
          fmt = 3'd1; v = longint'($signed(w[31:20]));
        end
      end
      'h23: begin fmt = 3'd2; v = longint'($signed({w[31:25], w[11:7]})); end
      'h63: begin fmt = 3'd3; v = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})); end
      'h37, 'h17: begin fmt = 3'd4; v = longint'($signed(w[31:12])) * 4096; end
      'h6F: begin fmt = 3'd5; v = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); end
      'h73: if (f3 >= 5) begin fmt = 3'd6; v = longint'(w[19:15]); end
      default: v = 0;
    endcase
    imm = (xl == 32) ? {32'd0, v[31:0]} : v;
  endfunction

  // Scoreboard: occupancy from exp_q predicts handshake outputs; pops check data.
  always @(negedge clk) begin
    logic [63:0] e, ximm;
    logic [2:0]  xfmt;
    logic        xerr;
    if (reset) begin
      stall_q = 1'b0;
    end else begin
      check("in_ready32", rdy32, exp_q.size() < 2);
      check("in_ready64", rdy64, exp_q.size() < 2);
      check("out_valid32", ov32, exp_q.size() > 0);
      check("out_valid64", ov64, exp_q.size() > 0);
      if (stall_q) check("hold_imm64", imm64, held_imm);
      if (ov32 && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_out++;
        ref_dec(e[31:0], 32, ximm, xfmt, xerr);
        check("imm32", imm32, ximm);
        check("fmt32", fmt32, xfmt);
        check("err32", err32, xerr);
        check("tag32", tag32, e[63:32]);
        ref_dec(e[31:0], 64, ximm, xfmt, xerr);
        check("imm64", imm64, ximm);
        check("fmt64", fmt64, xfmt);
        check("err64", err64, xerr);
        check("tag64", tag64, e[63:32]);
      end
      if (in_valid && rdy32) exp_q.push_back({in_tag, in_instr});
      stall_q  = ov64 && !out_ready;
      held_imm = imm64;
    end
  end

  task automatic send(input logic [31:0] w, input logic [31:0] t);
    int guard = 0;
    in_valid = 1'b1; in_instr = w; in_tag = t;
    do begin
      @(negedge clk);
      guard++;
    end while (!rdy32 && guard < 200);
    if (!rdy32) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic directed(input string name, input logic [31:0] w,
                          input logic [63:0] e32, input logic [2:0] f32, input logic r32,
                          input logic [63:0] e64, input logic [2:0] f64, input logic r64);
    logic [31:0] t;
    t = $urandom;
    drain();
    send(w, t);
    check({name, "_valid"}, ov32, 1);
    check({name, "_imm32"}, imm32, e32);
    check({name, "_fmt32"}, fmt32, f32);
    check({name, "_err32"}, err32, r32);
    check({name, "_tag"}, tag32, t);
    check({name, "_imm64"}, imm64, e64);
    check({name, "_fmt64"}, fmt64, f64);
    check({name, "_err64"}, err64, r64);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops[10] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33};
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 9)];
    return w;
  endfunction

  initial begin
    logic [31:0] bp[4];
    int k, n0, guard;
    bit done;
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", {ov64, ov32}, 2'b00);
    check("rst_in_ready", {rdy64, rdy32}, 2'b11);
    check("rst_imm", {imm32, imm64[31:0]}, 64'd0);
    check("rst_fmt_err", {fmt32, fmt64, err32, err64}, 8'd0);
    check("rst_tag", {tag32, tag64}, 64'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    directed("addi", 32'hFFF00093, 64'hFFFFFFFF, 3'd1, 0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 0);
    directed("sw", 32'hFE112E23, 64'hFFFFFFFC, 3'd2, 0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 0);
    directed("lui", 32'h800000B7, 64'h80000000, 3'd4, 0, 64'hFFFFFFFF80000000, 3'd4, 0);
    directed("slli63", 32'h03F09093, 64'd31, 3'd7, 1, 64'd63, 3'd7, 0);
    directed("csrrwi", 32'h0052D073, 64'd5, 3'd6, 0, 64'd5, 3'd6, 0);
    directed("rtype", 32'h002081B3, 64'd0, 3'd0, 0, 64'd0, 3'd0, 0);
    directed("beq_m4", 32'hFE000EE3, 64'hFFFFFFFC, 3'd3, 0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 0);
    directed("jal_m8", 32'hFF9FF06F, 64'hFFFFFFF8, 3'd5, 0, 64'hFFFFFFFFFFFFFFF8, 3'd5, 0);

    // Backpressure: four back-to-back offers against a stalled consumer.
    drain();
    bp[0] = 32'h00100093; bp[1] = 32'h00200113; bp[2] = 32'h00300193; bp[3] = 32'h00400213;
    out_ready = 1'b0; k = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (k < 4); in_instr = bp[k % 4]; in_tag = 32'h100 + k;
      @(negedge clk);
      check("bp_in_ready", rdy32, c < 2);
      if (rdy32 && in_valid) k++;
      @(posedge clk); #1;
    end
    check("bp_accepted", k, 2);
    n0 = n_out; out_ready = 1'b1; guard = 0;
    while (k < 4 && guard < 50) begin
      in_valid = 1'b1; in_instr = bp[k]; in_tag = 32'h100 + k;
      @(negedge clk);
      if (rdy32) k++;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    drain();
    check("bp_emerged", n_out - n0, 4);

    // Asynchronous reset with both buffers occupied.
    out_ready = 1'b0;
    send(32'h00500293, 32'hA);
    send(32'h00600313, 32'hB);
    @(posedge clk); #3;
    reset = 1'b1; #1;
    exp_q.delete();
    check("arst_out_valid", {ov64, ov32}, 2'b00);
    check("arst_in_ready", {rdy64, rdy32}, 2'b11);
    check("arst_imm", {imm32, imm64[31:0]}, 64'd0);
    check("arst_tag", {tag32, tag64}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    n0 = n_out;
    directed("post_rst", 32'hFFF00093, 64'hFFFFFFFF, 3'd1, 0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 0);
    drain();
    check("post_rst_count", n_out - n0, 1);

    // Random traffic with random consumer stalls.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send(rand_instr(), $urandom);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate generator.
- Decodes the immediate and instruction format from a 32-bit RV instruction, with sign-extension to XLEN (32 or 64).
- Adds CSR zimm and shift-amount forms, plus an illegal-format flag.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so decode can sit between fetch and the PMP-checked execute stage without combinational ready paths.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag (typically PC) carried alongside each instruction.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  instruction present on in_instr.
- in_ready  output  1  block can accept; registered, equals !skid_valid.
- in_instr  input  32  instruction word.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  output holds a decoded result.
- out_ready  input  1  consumer accepts this cycle.
- imm_out  output  XLEN  decoded immediate.
- fmt_out  output  3  format code: 0=NONE, 1=I, 2=S, 3=B, 4=U, 5=J, 6=Z (CSR zimm), 7=SH (shift amount).
- imm_err  output  1  format illegal for XLEN (shamt out of range).
- tag_out  output  TAG_W  tag aligned with imm_out.

Behaviour:
Decode is combinational, on opcode in_instr[6:0], funct3 [14:12] and sign bit s=[31]. Sign extension is always to XLEN.
- I: opcodes 0000011, 1100111, and 0010011 with funct3 not 001/101. imm = sext(instr[31:20]).
- SH: opcode 0010011 with funct3 001/101.
  - imm = zext(instr[25:20]) for XLEN=64.
  - imm = zext(instr[24:20]) for XLEN=32; instr[25]=1 sets imm_err.
- S: opcode 0100011. imm = sext({instr[31:25], instr[11:7]}).
- B: opcode 1100011. imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
- U: opcodes 0110111, 0010111. imm = sext({instr[31:12], 12'b0}); for XLEN=64, bits 63:32 = s.
- J: opcode 1101111. imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- Z: opcode 1110011 with funct3 in {101, 110, 111}. imm = zext(instr[19:15]).
- Anything else: fmt=NONE, imm=0, imm_err=0.

Pipeline:
- Accept when in_valid && in_ready. Latency is 1 cycle: the result appears on out_* the next cycle.
- Output register (main) plus one skid register.
- On accept:
  - If main is empty or is being consumed (out_ready) in the same cycle, the new result loads main.
  - Otherwise it loads skid, and in_ready drops next cycle.
- When main is consumed and skid_valid, skid moves to main and skid_valid clears.
- Simultaneous accept, consume and skid_valid cannot occur, because in_ready=0 whenever skid_valid.
- out_valid = main_valid. Outputs hold stable while out_valid && !out_ready.
- Order is strictly FIFO. No drop, no duplicate.
- Throughput is 1 per cycle when out_ready is held high.

Reset (asynchronous, any time including mid-transfer):
- main_valid=0, skid_valid=0, so out_valid=0 and in_ready=1.
- imm_out=0, fmt_out=0, imm_err=0, tag_out=0.
- In-flight entries are discarded.

Assertion:
- XLEN not in {32, 64} is a fatal elaboration error.

Decomposition:
- Shared package imm_pkg holds:
  - the fmt_e enum (3-bit codes above);
  - opcode constants OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM.
- One sub-module, imm_decode: purely combinational, parametrised on XLEN; produces imm, fmt, err.
- The top holds the handshake, main and skid registers.

Test Plan:
- XLEN=32, in 0xFFF00093 (addi x1,x0,-1), out_ready=1 → next cycle out_valid=1, imm_out=0xFFFFFFFF, fmt=I, imm_err=0, tag echoed.
- XLEN=32, in 0xFE112E23 (sw x1,-4(x2)) → imm_out=0xFFFFFFFC, fmt=S.
- XLEN=64, in 0x800000B7 (lui x1,0x80000) → imm_out=0xFFFFFFFF80000000, fmt=U. Then 0x03F09093 (slli x1,x1,63) → imm=63, fmt=SH, err=0. Same word at XLEN=32 → imm=31, imm_err=1.
- Backpressure: stream 4 instrs back-to-back with out_ready=0 → 2 accepted, in_ready=0 from cycle 2. Raise out_ready → all 4 emerge in order, one per cycle, none lost or duplicated.
- In 0x0052D073 (csrrwi x0,csr,5) → fmt=Z, imm=5. Opcode 0110011 (R-type) → fmt=NONE, imm=0.
- Assert reset asynchronously with main and skid full → out_valid=0, in_ready=1, imm_out=0 immediately. First post-reset instruction emerges alone and correctly.
